// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// i2c_bus_arbiter: round-robin single-owner arbitration of a shared open-drain I2C bus,
// with post-release bus-free gap and optional hold watchdog. Rev 1.0
module i2c_bus_arbiter #(
  parameter int REQUESTER_COUNT = 4,
  parameter int BUS_FREE_CYCLES = 500,
  parameter int MAX_HOLD_CYCLES = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [REQUESTER_COUNT-1:0] request,
  output logic [REQUESTER_COUNT-1:0] grant,
  input  logic [REQUESTER_COUNT-1:0] req_scl_output,
  input  logic [REQUESTER_COUNT-1:0] req_sda_output,
  output logic                       scl_output,
  output logic                       sda_output,
  output logic [2:0]                 owner,
  output logic                       busy,
  output logic                       timeout
);

  localparam int IW = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Where a release or revocation lands depends only on whether a gap is configured.
  localparam state_t      AFTER_STATE = (BUS_FREE_CYCLES != 0) ? RELEASE : IDLE;
  localparam logic [31:0] GAP_LOAD    = (BUS_FREE_CYCLES != 0) ? 32'(BUS_FREE_CYCLES - 1) : 32'd0;
  localparam logic [31:0] HOLD_LAST   = (MAX_HOLD_CYCLES != 0) ? 32'(MAX_HOLD_CYCLES - 1) : 32'd0;

  state_t                     state_q;
  logic [REQUESTER_COUNT-1:0] grant_q;
  logic [REQUESTER_COUNT-1:0] lockout_q;
  logic [2:0]                 owner_q;
  logic [31:0]                gap_q;
  logic [31:0]                hold_q;
  logic                       timeout_q;

  logic [IW-1:0]              owner_idx;
  logic [REQUESTER_COUNT-1:0] eligible;
  logic [REQUESTER_COUNT-1:0] owner_onehot;
  logic                       found_d;
  logic [2:0]                 owner_d;
  logic [REQUESTER_COUNT-1:0] grant_d;
  logic                       expire;

  assign owner_idx    = owner_q[IW-1:0];
  assign eligible     = request & ~lockout_q;
  assign owner_onehot = REQUESTER_COUNT'(1) << owner_idx;
  assign expire       = (MAX_HOLD_CYCLES != 0) && (hold_q == HOLD_LAST);

  // Scan offsets from farthest to nearest so the nearest eligible index after owner wins.
  always_comb begin
    logic [31:0] sum;
    sum     = 32'd0;
    found_d = 1'b0;
    owner_d = owner_q;
    grant_d = '0;
    for (int k = REQUESTER_COUNT; k >= 1; k--) begin
      sum = 32'(owner_q) + 32'(k);
      if (sum >= 32'(REQUESTER_COUNT)) begin
        sum = sum - 32'(REQUESTER_COUNT);
      end
      if (eligible[sum[IW-1:0]]) begin
        found_d             = 1'b1;
        owner_d             = sum[2:0];
        grant_d             = '0;
        grant_d[sum[IW-1:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= 3'(REQUESTER_COUNT - 1);
      lockout_q <= '0;
      gap_q     <= 32'd0;
      hold_q    <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      lockout_q <= lockout_q & request;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            owner_q <= owner_d;
            grant_q <= grant_d;
            hold_q  <= 32'd0;
            state_q <= GRANTED;
          end
        end
        GRANTED: begin
          if (!request[owner_idx]) begin
            grant_q <= '0;
            gap_q   <= GAP_LOAD;
            state_q <= AFTER_STATE;
          end else if (expire) begin
            grant_q   <= '0;
            timeout_q <= 1'b1;
            lockout_q <= (lockout_q & request) | owner_onehot;
            gap_q     <= GAP_LOAD;
            state_q   <= AFTER_STATE;
          end else if (hold_q != 32'hFFFF_FFFF) begin
            hold_q <= hold_q + 32'd1;
          end
        end
        RELEASE: begin
          if (gap_q == 32'd0) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign owner      = owner_q;
  assign busy       = (state_q != IDLE);
  assign timeout    = timeout_q;
  assign scl_output = (state_q == GRANTED) ? req_scl_output[owner_idx] : 1'b1;
  assign sda_output = (state_q == GRANTED) ? req_sda_output[owner_idx] : 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// tb_i2c_bus_arbiter: directed self-checking bench for i2c_bus_arbiter
// (gap of 4 cycles, 8-cycle hold watchdog). Rev 1.0
module tb_i2c_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] request = 4'b0000;
  logic [3:0] req_scl = 4'b1111;
  logic [3:0] req_sda = 4'b1111;
  logic [3:0] grant;
  logic       scl_output, sda_output, busy, timeout;
  logic [2:0] owner;

  int checks = 0;
  int fails  = 0;

  i2c_bus_arbiter #(
    .REQUESTER_COUNT(4),
    .BUS_FREE_CYCLES(4),
    .MAX_HOLD_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset), .request(request), .grant(grant),
    .req_scl_output(req_scl), .req_sda_output(req_sda),
    .scl_output(scl_output), .sda_output(sda_output),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (grant != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; request = 4'b0000; req_scl = 4'b0000; req_sda = 4'b0000;
    tick(); tick();
    checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
    checks++; if (owner !== 3'd3) begin fails++; $display("FAIL reset_owner: got %0d expected %0d", owner, 3); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    checks++; if (scl_output !== 1'b1) begin fails++; $display("FAIL reset_scl: got %b expected 1", scl_output); end
    checks++; if (sda_output !== 1'b1) begin fails++; $display("FAIL reset_sda: got %b expected 1", sda_output); end
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || scl_output !== 1'b1) begin fails++; $display("FAIL idle_after_reset: got busy=%b scl=%b expected busy=0 scl=1", busy, scl_output); end
    req_scl = 4'b1111; req_sda = 4'b1111;
  endtask

  task automatic test_grant();
    request = 4'b0101;
    tick();
    checks++; if (grant !== 4'b0001) begin fails++; $display("FAIL first_grant: got %b expected %b", grant, 4'b0001); end
    checks++; if (owner !== 3'd0) begin fails++; $display("FAIL first_owner: got %0d expected 0", owner); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL granted_busy: got %b expected 1", busy); end
    req_scl = 4'b1110; #1;
    checks++; if (scl_output !== 1'b0) begin fails++; $display("FAIL owner_scl_low: got %b expected 0", scl_output); end
    req_scl = 4'b1011; #1;
    checks++; if (scl_output !== 1'b1) begin fails++; $display("FAIL nonowner_scl_blocked: got %b expected 1", scl_output); end
    req_sda = 4'b1110; #1;
    checks++; if (sda_output !== 1'b0) begin fails++; $display("FAIL owner_sda_low: got %b expected 0", sda_output); end
    req_sda = 4'b1111;
  endtask

  task automatic test_release_gap();
    request = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b1 || scl_output !== 1'b1) begin fails++; $display("FAIL release_first: got grant=%b busy=%b scl=%b expected 0000 1 1", grant, busy, scl_output); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (grant !== 4'b0000 || busy !== 1'b1 || scl_output !== 1'b1) begin fails++; $display("FAIL release_gap[%0d]: got grant=%b busy=%b scl=%b expected 0000 1 1", i, grant, busy, scl_output); end
    end
    tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL gap_idle: got grant=%b busy=%b expected 0000 0", grant, busy); end
    tick();
    checks++; if (grant !== 4'b0100 || owner !== 3'd2) begin fails++; $display("FAIL post_gap_grant: got grant=%b owner=%0d expected 0100 2", grant, owner); end
    checks++; if (scl_output !== 1'b0) begin fails++; $display("FAIL new_owner_scl: got %b expected 0", scl_output); end
    req_scl = 4'b1111; request = 4'b0000;
    drain();
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [3:0] exp_g;
    int seq[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; tick(); reset = 1'b0;
    request = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << seq[n];
      wait_grant(ok);
      checks++; if (!ok) begin fails++; $display("FAIL rr_wait[%0d]: got no grant expected %b", n, exp_g); end
      checks++; if (grant !== exp_g || owner !== 3'(seq[n])) begin fails++; $display("FAIL rr_owner[%0d]: got grant=%b owner=%0d expected %b %0d", n, grant, owner, exp_g, seq[n]); end
      tick(); tick();
      checks++; if (grant !== exp_g) begin fails++; $display("FAIL rr_hold[%0d]: got %b expected %b", n, grant, exp_g); end
      request = 4'b1111 & ~exp_g;
      tick();
      checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL rr_release[%0d]: got %b expected 0000", n, grant); end
      request = 4'b1111;
    end
    request = 4'b0000;
    drain();
  endtask

  task automatic test_watchdog();
    bit ok;
    reset = 1'b1; tick(); reset = 1'b0;
    request = 4'b1010;
    wait_grant(ok);
    checks++; if (!ok || grant !== 4'b0010 || owner !== 3'd1) begin fails++; $display("FAIL wd_grant: got grant=%b owner=%0d expected 0010 1", grant, owner); end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++; if (grant !== 4'b0010 || timeout !== 1'b0) begin fails++; $display("FAIL wd_hold[%0d]: got grant=%b timeout=%b expected 0010 0", i, grant, timeout); end
    end
    tick();
    checks++; if (grant !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL wd_revoke: got grant=%b timeout=%b busy=%b expected 0000 1 1", grant, timeout, busy); end
    tick();
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL wd_pulse_width: got %b expected 0", timeout); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (grant !== 4'b0000) begin fails++; $display("FAIL wd_gap_end: got %b expected 0000", grant); end
    tick();
    checks++; if (grant !== 4'b1000 || owner !== 3'd3) begin fails++; $display("FAIL wd_next_owner: got grant=%b owner=%0d expected 1000 3", grant, owner); end
    request = 4'b0010;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL wd_lockout: got grant=%b busy=%b expected 0000 0", grant, busy); end
    request = 4'b0000; tick();
    request = 4'b0010;
    wait_grant(ok);
    checks++; if (!ok || grant !== 4'b0010) begin fails++; $display("FAIL wd_regrant: got %b expected 0010", grant); end
  endtask

  task automatic test_expiry_drop();
    bit ok;
    for (int i = 1; i < 8; i++) tick();
    request = 4'b0000;
    tick();
    checks++; if (timeout !== 1'b0 || grant !== 4'b0000) begin fails++; $display("FAIL drop_at_expiry: got timeout=%b grant=%b expected 0 0000", timeout, grant); end
    request = 4'b0010;
    tick();
    checks++; if (timeout !== 1'b0) begin fails++; $display("FAIL drop_no_pulse: got %b expected 0", timeout); end
    wait_grant(ok);
    checks++; if (!ok || grant !== 4'b0010) begin fails++; $display("FAIL drop_no_lockout: got %b expected 0010", grant); end
    request = 4'b0000;
    drain();
  endtask

  task automatic test_no_preempt();
    bit ok;
    request = 4'b0001;
    wait_grant(ok);
    checks++; if (!ok || grant !== 4'b0001) begin fails++; $display("FAIL np_grant: got %b expected 0001", grant); end
    request = 4'b0101; tick();
    checks++; if (grant !== 4'b0001) begin fails++; $display("FAIL np_hold_a: got %b expected 0001", grant); end
    request = 4'b1101; tick();
    checks++; if (grant !== 4'b0001) begin fails++; $display("FAIL np_hold_b: got %b expected 0001", grant); end
    request = 4'b0001; tick();
    request = 4'b0000; tick();
    drain();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL np_lost_request: got grant=%b busy=%b expected 0000 0", grant, busy); end
  endtask

  task automatic test_reset_midgrant();
    bit ok;
    request = 4'b0001;
    wait_grant(ok);
    req_scl = 4'b0000; req_sda = 4'b0000; #1;
    checks++; if (!ok || scl_output !== 1'b0) begin fails++; $display("FAIL rm_owner_drive: got scl=%b expected 0", scl_output); end
    reset = 1'b1;
    tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL rm_drop: got grant=%b busy=%b expected 0000 0", grant, busy); end
    checks++; if (scl_output !== 1'b1 || sda_output !== 1'b1 || owner !== 3'd3) begin fails++; $display("FAIL rm_bus: got scl=%b sda=%b owner=%0d expected 1 1 3", scl_output, sda_output, owner); end
    reset = 1'b0;
    tick();
    checks++; if (grant !== 4'b0001) begin fails++; $display("FAIL rm_regrant: got %b expected 0001", grant); end
    req_scl = 4'b1111; req_sda = 4'b1111; request = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_grant();
    test_release_gap();
    test_round_robin();
    test_watchdog();
    test_expiry_drop();
    test_no_preempt();
    test_reset_midgrant();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter REQUESTER_COUNT, default 4, meaning the number of requesters (legal range 1..8).
REQ-002 SHALL have parameter BUS_FREE_CYCLES, default 500, meaning the idle gap in clocks between a release and the next grant (0 = no gap).
REQ-003 SHALL have parameter MAX_HOLD_CYCLES, default 0, meaning the maximum number of clocks one owner may hold the grant (0 = watchdog disabled).
REQ-004 SHALL have port clock, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port request, input, REQUESTER_COUNT bits: per-requester bus request (level).
REQ-007 SHALL have port grant, output, REQUESTER_COUNT bits: per-requester grant (one-hot or zero, registered).
REQ-008 SHALL have port req_scl_output, input, REQUESTER_COUNT bits: open-drain SCL drive from each requester (1 = release).
REQ-009 SHALL have port req_sda_output, input, REQUESTER_COUNT bits: open-drain SDA drive from each requester (1 = release).
REQ-010 SHALL have port scl_output, output, 1 bit: shared SCL drive to the pad.
REQ-011 SHALL have port sda_output, output, 1 bit: shared SDA drive to the pad.
REQ-012 SHALL have port owner, output, 3 bits: index of the current or last owner.
REQ-013 SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-014 SHALL have port timeout, output, 1 bit: one-cycle pulse when the watchdog revokes a grant.

Function
REQ-015 SHALL implement the states IDLE, GRANTED and RELEASE.
REQ-016 IDLE: when any eligible request is high, SHALL register owner, set grant to one-hot(owner) and go to GRANTED on the same edge; grant is therefore visible 1 cycle after the request is sampled.
REQ-017 Eligibility SHALL be request[i] high and lockout[i] low.
REQ-018 Selection SHALL be round-robin: search starts at (owner+1) mod REQUESTER_COUNT, and the first eligible index wins.
REQ-019 GRANTED: when request[owner] is low, SHALL clear grant on the next edge; if BUS_FREE_CYCLES != 0, SHALL load gap_count = BUS_FREE_CYCLES-1 and go to RELEASE, else go to IDLE.
REQ-020 RELEASE: gap_count SHALL decrement each cycle, and the state SHALL go to IDLE on the cycle gap_count == 0; requests SHALL be ignored during RELEASE.
REQ-021 scl_output/sda_output SHALL be combinational: req_*_output[owner] in GRANTED, and constant 1 in IDLE and RELEASE; non-owner drives SHALL never reach the pad.
REQ-022 hold_count SHALL clear on grant and increment each cycle in GRANTED, saturating at its width of 32 bits.
REQ-023 If MAX_HOLD_CYCLES != 0 and hold_count == MAX_HOLD_CYCLES-1 while request[owner] is still high, the block SHALL: clear grant, pulse timeout for 1 cycle, set lockout[owner], and enter RELEASE (or IDLE if BUS_FREE_CYCLES == 0).
REQ-024 lockout[i] SHALL clear on the first cycle request[i] is sampled low; a locked-out requester SHALL not be granted until then.
REQ-025 If request[owner] drops on the same cycle the watchdog expires, the block SHALL treat it as a normal release: no timeout pulse and no lockout.
REQ-026 Requests from non-owners SHALL never preempt the current owner.
REQ-027 grant SHALL never have more than one bit set.
REQ-028 A request that rises and falls while another owner holds the bus SHALL be lost; there is no queueing.
REQ-029 With REQUESTER_COUNT == 1 the block SHALL behave as a pass-through with gap and watchdog still applied.

Reset
REQ-030 On reset the block SHALL set state=IDLE, grant=0, owner=REQUESTER_COUNT-1 (so requester 0 has first priority), lockout=0, gap_count=0, hold_count=0 and timeout=0; scl_output/sda_output are therefore 1.
REQ-031 Reset asserted mid-grant SHALL take effect on the next edge: grant drops and the bus is released without a RELEASE gap.

Verification
REQ-032 After reset, request=4'b0101 at cycle 0 -> grant=4'b0001 at cycle 1, owner=0; req_scl_output[0]=0 -> scl_output=0; req_scl_output[2]=0 -> scl_output unchanged.
REQ-033 With BUS_FREE_CYCLES=4, owner 0 drops its request at cycle 10 while request[2] stays high -> grant=0 at cycle 11, busy=1 and scl/sda=1 for cycles 11..14, grant=4'b0100 at cycle 16.
REQ-034 With all four requests held continuously and each owner releasing after 3 grant cycles, the owner sequence SHALL be 0,1,2,3,0.
REQ-035 With MAX_HOLD_CYCLES=8 and owner 1 holding forever -> grant clears after 8 grant cycles, timeout=1 for exactly 1 cycle, and requester 1 is not re-granted until request[1] toggles low then high; requester 3 is granted after the gap.
REQ-036 Drop request[owner] on the exact watchdog-expiry cycle -> timeout stays 0 and lockout stays 0.
REQ-037 Assert reset while granted with BUS_FREE_CYCLES=500 -> the next cycle has grant=0, busy=0 and scl_output=sda_output=1; with request[0] high, a re-grant occurs at the cycle after reset deasserts +1.
